// File: rtl/taylor_pkg.sv
// Purpose : shared fixed-point types and scheduler state encoding for the taylor cosine path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package taylor_pkg;

  localparam int FXP_W    = 24;
  localparam int FXP_FRAC = 10;
  localparam int FXP_ONE  = 1024;

  // Q2.10 angle / cosine value carried in a 24-bit container.
  typedef logic [FXP_W-1:0] fxp_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/taylor_sched_rr_arbiter.sv
// Purpose : combinational round-robin arbiter; grants the first requester found searching from ptr upward.
// Latency : zero cycles (pure combinational).
// Backpressure: none; gnt is all-zero when no req bit is set.
// Ports   : req[N] request vector, ptr search start index, gnt[N] one-hot grant, gnt_idx binary grant index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    logic found;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Walk the N positions starting at ptr, wrapping at N; first hit wins.
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/taylor_sched.sv
// Purpose : round-robin scheduler sharing one taylor_rtl cosine core among NREQ requesters, with a WAIT timeout.
// Latency : grant edge T0, core_start T0+1..T0+START_CYCLES, result pulse one cycle after the core_ready rising edge.
// Backpressure: req_ready is only offered in IDLE; requesters hold valid/angle until granted.
// Ports   : clock/reset (async active-low); req_valid/req_angle/req_ready requester handshake;
//           rsp_valid/rsp_cos/rsp_timeout result pulse; busy; core_start/core_angle/core_ready/core_cos to the core.
module taylor_sched
  import taylor_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int START_CYCLES = 3,
  parameter int TIMEOUT      = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*FXP_W-1:0] req_angle,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output fxp_t                  rsp_cos,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  core_start,
  output fxp_t                  core_angle,
  input  logic                  core_ready,
  input  fxp_t                  core_cos
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  sched_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   g_q, g_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  fxp_t            angle_q, angle_d;
  fxp_t            cos_q, cos_d;
  logic            to_q, to_d;
  logic            rdy_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            rise;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // rdy_q follows core_ready in every state, so a ready left high from a
  // previous operation never looks like a fresh edge on WAIT entry.
  assign rise = core_ready & ~rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    angle_d = angle_q;
    cos_d   = cos_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        // gnt is a subset of req_valid, so any grant bit means a transfer.
        if (|gnt) begin
          angle_d = req_angle[int'(gnt_idx)*FXP_W +: FXP_W];
          g_d     = gnt_idx;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // The edge check precedes the timeout so a late answer on the final
        // cycle still returns the real result.
        if (rise) begin
          cos_d   = core_cos;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cos_d   = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      angle_q <= '0;
      cos_q   <= '0;
      to_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      angle_q <= angle_d;
      cos_q   <= cos_d;
      to_q    <= to_d;
      rdy_q   <= core_ready;
    end
  end

  // Grant is masked by reset so every output reads zero while reset is held,
  // even with requests pending.
  assign req_ready   = (state_q == S_IDLE && reset) ? gnt : '0;
  assign rsp_valid   = (state_q == S_RESP) ? (NREQ'(1) << g_q) : '0;
  assign rsp_cos     = cos_q;
  assign rsp_timeout = to_q;
  assign busy        = (state_q != S_IDLE);
  assign core_start  = (state_q == S_START);
  assign core_angle  = angle_q;

endmodule

// File: tb/tb_taylor_sched.sv
// Purpose : directed self-checking bench for taylor_sched with a hand-driven core model.
// Latency : n/a.
// Backpressure: n/a.
module tb_taylor_sched;
  import taylor_pkg::*;

  localparam int NREQ = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*FXP_W-1:0] req_angle;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  fxp_t                  rsp_cos;
  logic                  rsp_timeout;
  logic                  busy;
  logic                  core_start;
  fxp_t                  core_angle;
  logic                  core_ready;
  fxp_t                  core_cos;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  taylor_sched #(.NREQ(NREQ), .START_CYCLES(3), .TIMEOUT(256)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_angle   (req_angle),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_cos     (rsp_cos),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .core_start  (core_start),
    .core_angle  (core_angle),
    .core_ready  (core_ready),
    .core_cos    (core_cos)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_angle(input int i, input logic [23:0] a);
    req_angle[i*FXP_W +: FXP_W] = a;
  endtask

  // From an IDLE cycle with a grant offered: take the transfer edge, then
  // count core_start cycles until WAIT entry.
  task automatic to_wait(output int sc);
    step;
    sc = 0;
    while (core_start === 1'b1 && sc < 16) begin
      sc++;
      step;
    end
  endtask

  // Core answers after dly WAIT cycles; returns in the RESP cycle.
  task automatic answer(input int dly, input logic [23:0] c);
    repeat (dly) step;
    core_ready = 1'b1;
    core_cos   = c;
    step;
    core_ready = 1'b0;
  endtask

  logic [23:0] ang_tab [4];
  logic [23:0] cos_tab [4];

  initial begin
    int sc;
    int n;
    ang_tab = '{24'd0, 24'd256, 24'd512, 24'd1024};
    cos_tab = '{24'd1024, 24'd992, 24'd899, 24'd553};

    reset      = 1'b0;
    req_valid  = '0;
    req_angle  = '0;
    core_ready = 1'b0;
    core_cos   = '0;
    step;
    step;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_angle", 32'(core_angle), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_cos", 32'(rsp_cos), 32'd0);
    chk("rst_timeout", 32'(rsp_timeout), 32'd0);
    reset = 1'b1;
    step;

    // Single request from requester 0.
    set_angle(0, 24'd512);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_idle_busy", 32'(busy), 32'd0);
    to_wait(sc);
    req_valid = '0;
    chk("single_start_cycles", 32'(sc), 32'd3);
    chk("single_angle", 32'(core_angle), 32'd512);
    chk("single_wait_busy", 32'(busy), 32'd1);
    answer(0, 24'd899);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_cos", 32'(rsp_cos), 32'd899);
    chk("single_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("single_resp_busy", 32'(busy), 32'd1);
    step;
    chk("single_after_busy", 32'(busy), 32'd0);
    chk("single_after_valid", 32'(rsp_valid), 32'd0);

    // Fairness: restart from ptr=0 with all four requesters active.
    reset = 1'b0;
    step;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_angle(i, ang_tab[i]);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      chk("fair_grant", 32'(req_ready), 32'(1) << g);
      to_wait(sc);
      chk("fair_angle", 32'(core_angle), 32'(ang_tab[g]));
      answer(1, cos_tab[g]);
      chk("fair_rsp_valid", 32'(rsp_valid), 32'(1) << g);
      chk("fair_rsp_cos", 32'(rsp_cos), 32'(cos_tab[g]));
      step;
    end
    req_valid = '0;

    // Timeout: requester 1, core never answers.
    set_angle(1, 24'd100);
    req_valid = 4'b0010;
    #1;
    chk("to_grant", 32'(req_ready), 32'h2);
    to_wait(sc);
    req_valid = '0;
    n = 0;
    while (rsp_valid == '0 && n < 400) begin
      step;
      n++;
    end
    chk("to_cycles", 32'(n), 32'd256);
    chk("to_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_cos", 32'(rsp_cos), 32'd0);
    step;

    // Next request proceeds normally (requester 3; ptr now 2).
    set_angle(3, 24'd256);
    req_valid = 4'b1000;
    #1;
    chk("post_to_grant", 32'(req_ready), 32'h8);
    to_wait(sc);
    req_valid = '0;
    answer(2, 24'd992);
    chk("post_to_valid", 32'(rsp_valid), 32'h8);
    chk("post_to_cos", 32'(rsp_cos), 32'd992);
    chk("post_to_flag", 32'(rsp_timeout), 32'd0);
    step;

    // Stale ready: held high from before the grant.
    core_ready = 1'b1;
    core_cos   = 24'd777;
    set_angle(0, 24'd512);
    req_valid  = 4'b0001;
    #1;
    chk("stale_grant", 32'(req_ready), 32'h1);
    to_wait(sc);
    req_valid = '0;
    step;
    chk("stale_w1", 32'(rsp_valid), 32'd0);
    step;
    core_ready = 1'b0;
    chk("stale_w2", 32'(rsp_valid), 32'd0);
    step;
    step;
    step;
    chk("stale_w5", 32'(rsp_valid), 32'd0);
    core_ready = 1'b1;
    core_cos   = 24'd899;
    step;
    core_ready = 1'b0;
    chk("stale_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("stale_rsp_cos", 32'(rsp_cos), 32'd899);
    step;

    // Reset mid-WAIT with requester 1 in flight.
    set_angle(1, 24'd256);
    req_valid = 4'b0010;
    #1;
    to_wait(sc);
    step;
    step;
    step;
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_start", 32'(core_start), 32'd0);
    chk("midrst_angle", 32'(core_angle), 32'd0);
    chk("midrst_rsp_cos", 32'(rsp_cos), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    step;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b0011;
    set_angle(0, 24'd0);
    #1;
    chk("midrst_ptr0_grant", 32'(req_ready), 32'h1);
    to_wait(sc);
    req_valid = '0;
    answer(1, 24'd1024);
    chk("midrst_rsp_valid2", 32'(rsp_valid), 32'h1);
    step;

    // req_valid dropping in IDLE before any edge: no side effect.
    req_valid = 4'b0100;
    #1;
    chk("drop_ready_seen", 32'(req_ready), 32'h4);
    req_valid = '0;
    #1;
    chk("drop_ready_gone", 32'(req_ready), 32'd0);
    step;
    chk("drop_busy", 32'(busy), 32'd0);

    // Ready edge on the final timeout cycle: edge wins (ptr=1, grant 2).
    set_angle(2, 24'd1024);
    req_valid = 4'b0100;
    #1;
    chk("edge_to_grant", 32'(req_ready), 32'h4);
    to_wait(sc);
    req_valid = '0;
    answer(255, 24'd553);
    chk("edge_to_valid", 32'(rsp_valid), 32'h4);
    chk("edge_to_flag", 32'(rsp_timeout), 32'd0);
    chk("edge_to_cos", 32'(rsp_cos), 32'd553);
    step;
    chk("edge_to_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
